// File: rtl/mo_descriptor_scan_pkg.sv
// Shared types and constants for the motion-object descriptor scanner.
package mo_pkg;

  typedef struct packed {
    logic [7:0] pic;
    logic [3:0] row;
    logic [7:0] hpos;
    logic [7:0] attr;
  } mo_desc_t;

  typedef enum logic {
    W0 = 1'b0,
    W1 = 1'b1
  } scan_state_t;

  localparam logic [1:0] SAMPLE_PHASE = 2'b11;
  localparam logic [5:0] HITCNT_MAX   = 6'd63;

endpackage

// File: rtl/mo_descriptor_scan_if.sv
// Valid/ready stream carrying one hit descriptor to the picture-ROM fetcher.
interface mo_descriptor_scan_if;
  import mo_pkg::*;

  logic       valid;
  logic       ready;
  logic [7:0] pic;
  logic [3:0] row;
  logic [7:0] hpos;
  logic [7:0] attr;

  modport master (output valid, pic, row, hpos, attr, input ready);
  modport slave  (input valid, pic, row, hpos, attr, output ready);

endinterface

// File: rtl/mo_descriptor_scan_fifo.sv
// Synchronous descriptor FIFO with flush; a pop frees a slot for a push on the same edge.
module mo_fifo
  import mo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     flush,
  input  logic     push,
  input  mo_desc_t din,
  input  logic     pop,
  output mo_desc_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  mo_desc_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Head is forced to zero when empty so the outputs are clean out of reset.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mo_descriptor_scan.sv
// Pairs working-RAM words into motion-object descriptors and queues those on the line.
// Optional MO_SCAN_FLIP_EN adds a flip input that mirrors row and hpos.
//
// state | meaning
// W0    | waiting for word0 (vpos/pic) on an even slot
// W1    | word0 held, waiting for word1 (hpos/attr) on an odd slot
module mo_descriptor_scan
  import mo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HEIGHT     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [8:0]  hcount,
  input  logic [7:0]  vcount,
  input  logic        b2h,
  input  logic [15:0] sr,
`ifdef MO_SCAN_FLIP_EN
  input  logic        flip,
`endif
  output logic [5:0]  hit_count,
  output logic        overflow,
  output logic        miss,
  mo_descriptor_scan_if.master mo_out
);

  localparam logic [8:0] HEIGHT_C  = 9'(HEIGHT);
  localparam logic [3:0] ROW_MAX_C = 4'(HEIGHT - 1);

  scan_state_t state_q;
  scan_state_t state_d;

  logic       slot;
  logic       sample;
  logic       odd_word;
  logic       line_start;
  logic       latch_w0;
  logic       eval;
  logic [7:0] vpos_q;
  logic [7:0] pic_q;
  logic [7:0] diff;
  logic       hit;
  logic [3:0] row;
  logic [7:0] hpos;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  mo_desc_t   entry;
  mo_desc_t   head;

  assign slot       = (hcount[1:0] == SAMPLE_PHASE);
  assign sample     = slot && !b2h;
  assign odd_word   = hcount[2];
  assign line_start = (hcount == 9'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        state_q <= W0;
    else if (line_start) state_q <= W0;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sample) begin
      case (state_q)
        W0:      if (!odd_word) state_d = W1;
        W1:      if (odd_word)  state_d = W0;
        default: state_d = W0;
      endcase
    end
  end

  // An even word in W1 simply replaces the held word0.
  always_comb begin
    latch_w0 = sample && !odd_word;
    eval     = sample && odd_word && (state_q == W1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpos_q <= '0;
      pic_q  <= '0;
    end else if (latch_w0) begin
      vpos_q <= sr[15:8];
      pic_q  <= sr[7:0];
    end
  end

  assign diff = vcount - vpos_q;
  assign hit  = eval && ({1'b0, diff} < HEIGHT_C);

`ifdef MO_SCAN_FLIP_EN
  assign row  = flip ? (ROW_MAX_C - diff[3:0]) : diff[3:0];
  assign hpos = flip ? ~sr[15:8] : sr[15:8];
`else
  assign row  = diff[3:0];
  assign hpos = sr[15:8];
`endif

  always_comb begin
    entry      = '0;
    entry.pic  = pic_q;
    entry.row  = row;
    entry.hpos = hpos;
    entry.attr = sr[7:0];
  end

  assign pop = mo_out.valid && mo_out.ready && !line_start;

  mo_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (line_start),
    .push    (hit),
    .din     (entry),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign mo_out.valid = !fifo_empty;
  assign mo_out.pic   = head.pic;
  assign mo_out.row   = head.row;
  assign mo_out.hpos  = head.hpos;
  assign mo_out.attr  = head.attr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count <= '0;
      overflow  <= 1'b0;
      miss      <= 1'b0;
    end else if (line_start) begin
      hit_count <= '0;
      overflow  <= 1'b0;
      miss      <= 1'b0;
    end else begin
      if (hit && (hit_count != HITCNT_MAX)) hit_count <= hit_count + 6'd1;
      // A full FIFO only drops the hit when no pop frees a slot on this edge.
      if (hit && fifo_full && !pop) overflow <= 1'b1;
      if (slot && b2h) miss <= 1'b1;
    end
  end

endmodule
